// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with an IDLE/FETCH/EXEC(/TRAP) FSM.
// The current PC is registered. pc_plus4 is derived from it combinationally.
// fetch_req, commit and trap are registered outputs. commit is high in the
// cycle where the new PC first appears on pc.
// Optional feature macro: PC_MISALIGN_TRAP_EN.
//   Defined   - a branch or jump to a non-word-aligned target enters TRAP,
//               then reloads the PC with TRAP_VECTOR.
//   Undefined - there is no TRAP state and trap is tied low. Target bits
//               [1:0] are cleared, so EXEC always commits.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [1:0]  PCSrc,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_req,
    output logic        commit,
    output logic        trap
);

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetchReq_q, fetchReq_d;
    logic        commit_q, commit_d;
    logic [31:0] selTarget;

`ifdef PC_MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic        misaligned;
`else
    logic        unusedTrapVector;
`endif

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign fetch_req = fetchReq_q;
    assign commit   = commit_q;

`ifdef PC_MISALIGN_TRAP_EN
    assign trap = trap_q;
    // Only branch and jump can be misaligned. The sequential pc+4 path never is.
    assign misaligned = ((PCSrc == 2'b01) || (PCSrc == 2'b10)) && (selTarget[1:0] != 2'b00);
`else
    assign trap = 1'b0;
    assign unusedTrapVector = ^TRAP_VECTOR;
`endif

    // Next-PC source select. The reserved encoding 11 falls back to pc+4.
    always_comb begin
        selTarget = pc_plus4;
        case (PCSrc)
            2'b01:   selTarget = branch_target;
            2'b10:   selTarget = jump_target;
            default: selTarget = pc_plus4;
        endcase
    end

    // Next-state logic. Each output is computed for the state being entered,
    // so after registering it lines up with that state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetchReq_d = 1'b0;
        commit_d   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                state_d    = FETCH;
                fetchReq_d = 1'b1;
            end
            FETCH: begin
                if (imem_ready) begin
                    state_d = EXEC;
                end else begin
                    fetchReq_d = 1'b1;
                end
            end
            EXEC: begin
                if (!stall) begin
`ifdef PC_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_d = TRAP;
                        trap_d  = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        pc_d       = selTarget;
                        commit_d   = 1'b1;
                        fetchReq_d = 1'b1;
                    end
`else
                    state_d    = FETCH;
                    pc_d       = selTarget & 32'hFFFF_FFFC;
                    commit_d   = 1'b1;
                    fetchReq_d = 1'b1;
`endif
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            TRAP: begin
                state_d    = FETCH;
                pc_d       = TRAP_VECTOR;
                fetchReq_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset abandons any fetch, exec or trap in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            fetchReq_q <= 1'b0;
            commit_q   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetchReq_q <= fetchReq_d;
            commit_q   <= commit_d;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q     <= trap_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Every commit or trap event expected from the stimulus is queued.
// A monitor pops and compares each event as the DUT raises commit or trap.
module tb_pc_sequencer;

`ifdef PC_MISALIGN_TRAP_EN
   localparam bit TrapEn = 1'b1;
`else
   localparam bit TrapEn = 1'b0;
`endif
   localparam logic [31:0] ResetVector = 32'h0000_0000;
   localparam logic [31:0] TrapVector  = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic [31:0] branchTarget;
   logic [31:0] jumpTarget;
   logic [1:0]  pcSrc;
   logic        stall;
   logic        imemReady;
   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic        fetchReq;
   logic        commit;
   logic        trap;

   typedef struct {
      bit          isTrap;
      logic [31:0] pc;
   } expEvent_t;

   expEvent_t expQ[$];
   expEvent_t expHead;
   int nCompared;
   int nMismatched;

   pc_sequencer #(
      .RESET_VECTOR(ResetVector),
      .TRAP_VECTOR (TrapVector)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .branch_target(branchTarget),
      .jump_target  (jumpTarget),
      .PCSrc        (pcSrc),
      .stall        (stall),
      .imem_ready   (imemReady),
      .pc           (pc),
      .pc_plus4     (pcPlus4),
      .fetch_req    (fetchReq),
      .commit       (commit),
      .trap         (trap)
   );

   // 10 time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: actual=%h required=%h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next falling edge
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Scoreboard monitor: every commit/trap pulse must match the queue head
   always @(negedge clk) begin
      if (commit || trap) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedEvent", {30'b0, commit, trap}, 32'd0);
         end else begin
            expHead = expQ.pop_front();
            checkOutput(expHead.isTrap ? "trapPulse" : "commitPulse",
                        {30'b0, trap, commit}, expHead.isTrap ? 32'd2 : 32'd1);
            checkOutput("eventPc", pc, expHead.pc);
         end
      end
   end

   // Assert reset away from a clock edge and check the asynchronous effect.
   // Then release it and check the single IDLE cycle and the reset-vector fetch.
   task automatic resetDut();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rstPc", pc, ResetVector);
      checkOutput("rstFetchReq", {31'b0, fetchReq}, 32'd0);
      checkOutput("rstCommit", {31'b0, commit}, 32'd0);
      checkOutput("rstTrap", {31'b0, trap}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      checkOutput("idleFetchReq", {31'b0, fetchReq}, 32'd0);
      step();
      checkOutput("firstFetchReq", {31'b0, fetchReq}, 32'd1);
      checkOutput("firstFetchPc", pc, ResetVector);
   endtask

   // Run one instruction from FETCH through EXEC. Optional stall cycles
   // precede resolution. expPc is the committed PC, or the post-trap PC
   // when expTrap is set.
   task automatic applyStimulus(input logic [1:0] src, input logic [31:0] br, input logic [31:0] jt,
                                input int stallCycles, input bit expTrap, input logic [31:0] expPc);
      logic [31:0] held;
      imemReady = 1'b1;
      step();
      checkOutput("execFetchReq", {31'b0, fetchReq}, 32'd0);
      held = pc;
      pcSrc = src;
      branchTarget = br;
      jumpTarget = jt;
      stall = (stallCycles > 0);
      for (int i = 0; i < stallCycles; i++) begin
         step();
         checkOutput("stallPcHeld", pc, held);
         checkOutput("stallCommit", {31'b0, commit}, 32'd0);
      end
      stall = 1'b0;
      expQ.push_back('{isTrap: expTrap, pc: expTrap ? held : expPc});
      step();
      checkOutput("eventSeen", expQ.size(), 32'd0);
      if (expTrap) begin
         step();
         checkOutput("trapOneCycle", {31'b0, trap}, 32'd0);
         checkOutput("trapVectorPc", pc, expPc);
      end
      checkOutput("nextFetchReq", {31'b0, fetchReq}, 32'd1);
   endtask

   initial begin
      nCompared = 0;
      nMismatched = 0;
      rst = 1'b1;
      branchTarget = 32'd0;
      jumpTarget = 32'd0;
      pcSrc = 2'b00;
      stall = 1'b0;
      imemReady = 1'b0;

      resetDut();

      // Sequential flow: 0 -> 4 -> 8
      applyStimulus(2'b00, 32'd0, 32'd0, 0, 1'b0, 32'd4);
      applyStimulus(2'b00, 32'd0, 32'd0, 0, 1'b0, 32'd8);

      // Jump to 100, branch to 500, jump to 900
      applyStimulus(2'b10, 32'd0, 32'd100, 0, 1'b0, 32'd100);
      applyStimulus(2'b01, 32'd500, 32'd0, 0, 1'b0, 32'd500);
      applyStimulus(2'b10, 32'd0, 32'd900, 0, 1'b0, 32'd900);

      // Three stall cycles in EXEC before a branch
      applyStimulus(2'b01, 32'h0000_1000, 32'd0, 3, 1'b0, 32'h0000_1000);

      // FETCH waits while the instruction memory is not ready
      imemReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("fetchWaitReq", {31'b0, fetchReq}, 32'd1);
         checkOutput("fetchWaitPc", pc, 32'h0000_1000);
      end

      // Reserved select falls back to pc+4
      applyStimulus(2'b11, 32'h0000_2000, 32'h0000_3000, 0, 1'b0, 32'h0000_1004);

      // pc+4 wraps modulo 2^32
      applyStimulus(2'b10, 32'd0, 32'hFFFF_FFFC, 0, 1'b0, 32'hFFFF_FFFC);
      checkOutput("wrapPlus4", pcPlus4, 32'h0000_0000);
      applyStimulus(2'b00, 32'd0, 32'd0, 0, 1'b0, 32'h0000_0000);

      // Misaligned jump and branch: trap or forced alignment, depending on build
      applyStimulus(2'b10, 32'd0, 32'd902, 0, TrapEn, TrapEn ? TrapVector : 32'd900);
      applyStimulus(2'b01, 32'h0000_0503, 32'd0, 1, TrapEn, TrapEn ? TrapVector : 32'h0000_0500);
      // Misaligned targets are irrelevant when pc+4 is selected
      applyStimulus(2'b00, 32'h0000_0003, 32'h0000_0003, 0, 1'b0,
                    TrapEn ? 32'h0000_0104 : 32'h0000_0504);

      // Reset mid-FETCH with imem_ready low
      imemReady = 1'b0;
      step();
      step();
      resetDut();

      // Reset mid-EXEC with a resolution pending: no commit must appear
      imemReady = 1'b1;
      step();
      pcSrc = 2'b10;
      jumpTarget = 32'h0000_0040;
      stall = 1'b0;
      resetDut();
      applyStimulus(2'b10, 32'd0, 32'h0000_0044, 0, 1'b0, 32'h0000_0044);

`ifdef PC_MISALIGN_TRAP_EN
      // Reset while in TRAP: the PC must not load the trap vector
      imemReady = 1'b1;
      step();
      pcSrc = 2'b10;
      jumpTarget = 32'h0000_0046;
      expQ.push_back('{isTrap: 1'b1, pc: 32'h0000_0044});
      step();
      resetDut();
      checkOutput("trapAbandonPc", pc, ResetVector);
`endif

      checkOutput("queueDrained", expQ.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
